// File: rtl/hvac_pkg.sv
// Shared types for the HVAC zone scheduler: FSM state and plant mode encodings,
// plus a one-hot to index helper for blocks that carry grants as one-hot vectors.
package hvac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    RUN   = 3'b010,
    DWELL = 3'b100
  } state_t;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_t;

  localparam int MAX_ZONES = 16;

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_ZONES-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_ZONES; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/hvac_rr_arbiter.sv
// Combinational round-robin pick: searches ptr+1 .. ptr+N-1 and finally ptr itself,
// so the last winner has lowest priority.
module hvac_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_valid
);

  int          j;
  logic [IW-1:0] jj;

  // Walk from lowest priority to highest so the highest-priority hit is written last.
  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = N; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (valid[jj]) begin
        winner    = jj;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Grants one shared heater/cooler plant to one zone at a time with round-robin
// fairness, a minimum on-time, a run quantum and a mandatory off-dwell.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NUM_ZONES   = 4,
  parameter int MIN_ON_CYC  = 16,
  parameter int MAX_ON_CYC  = 64,
  parameter int MIN_OFF_CYC = 8,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ZONES-1:0] heat_req,
  input  logic [NUM_ZONES-1:0] cool_req,
  output logic [NUM_ZONES-1:0] zone_grant,
  output logic                 heater_on,
  output logic                 cooler_on,
  output logic [NUM_ZONES-1:0] req_conflict,
  output logic                 busy
);

  localparam int IW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam logic [CNT_W-1:0] MIN_ON  = CNT_W'(MIN_ON_CYC);
  localparam logic [CNT_W-1:0] MAX_ON  = CNT_W'(MAX_ON_CYC);
  localparam logic [CNT_W-1:0] MIN_OFF = CNT_W'(MIN_OFF_CYC);

  state_t               state, state_n;
  mode_t                mode, mode_n;
  logic [IW-1:0]        ptr, ptr_n;
  logic [CNT_W-1:0]     run_cnt, run_n;
  logic [CNT_W-1:0]     dwell_cnt, dwell_n;
  logic [NUM_ZONES-1:0] grant_n;
  logic                 heat_n, cool_n, busy_n;

  logic [NUM_ZONES-1:0] valid;
  logic [IW-1:0]        winner;
  logic                 any_valid;
  logic                 req_cur, others, release_req;

  assign valid        = heat_req ^ cool_req;
  assign req_conflict = heat_req & cool_req;

  hvac_rr_arbiter #(.N(NUM_ZONES), .IW(IW)) u_arb (
    .valid     (valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The granted zone is always ptr while running; a mode flip reads as a drop.
  assign req_cur     = (mode == MODE_HEAT) ? heat_req[ptr] : cool_req[ptr];
  assign others      = |(valid & ~zone_grant);
  assign release_req = !req_cur || ((run_cnt >= MAX_ON) && others);

  always_comb begin
    state_n = state;
    mode_n  = mode;
    ptr_n   = ptr;
    run_n   = run_cnt;
    dwell_n = dwell_cnt;
    grant_n = zone_grant;
    heat_n  = heater_on;
    cool_n  = cooler_on;
    case (state)
      IDLE: begin
        grant_n = '0;
        heat_n  = 1'b0;
        cool_n  = 1'b0;
        if (any_valid) begin
          state_n          = RUN;
          ptr_n            = winner;
          mode_n           = heat_req[winner] ? MODE_HEAT : MODE_COOL;
          run_n            = CNT_W'(1);
          grant_n[winner]  = 1'b1;
          heat_n           = heat_req[winner];
          cool_n           = !heat_req[winner];
        end
      end
      RUN: begin
        if (run_cnt != '1) run_n = run_cnt + 1'b1;
        if (release_req && (run_cnt >= MIN_ON)) begin
          state_n = DWELL;
          run_n   = '0;
          dwell_n = MIN_OFF;
          grant_n = '0;
          heat_n  = 1'b0;
          cool_n  = 1'b0;
        end
      end
      DWELL: begin
        grant_n = '0;
        heat_n  = 1'b0;
        cool_n  = 1'b0;
        if (dwell_cnt <= CNT_W'(1)) begin
          state_n = IDLE;
          dwell_n = '0;
        end else begin
          dwell_n = dwell_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        run_n   = '0;
        dwell_n = '0;
        grant_n = '0;
        heat_n  = 1'b0;
        cool_n  = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode       <= MODE_HEAT;
      ptr        <= IW'(NUM_ZONES - 1);
      run_cnt    <= '0;
      dwell_cnt  <= '0;
      zone_grant <= '0;
      heater_on  <= 1'b0;
      cooler_on  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      ptr        <= ptr_n;
      run_cnt    <= run_n;
      dwell_cnt  <= dwell_n;
      zone_grant <= grant_n;
      heater_on  <= heat_n;
      cooler_on  <= cool_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Directed bench for hvac_zone_scheduler with NUM_ZONES=4, MIN_ON=4, MAX_ON=8, MIN_OFF=2.
module tb_hvac_zone_scheduler;

  localparam int NZ = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NZ-1:0] heat_req = '0;
  logic [NZ-1:0] cool_req = '0;
  logic [NZ-1:0] zone_grant, req_conflict;
  logic          heater_on, cooler_on, busy;
  int            n_vec = 0;
  int            n_err = 0;

  hvac_zone_scheduler #(
    .NUM_ZONES(NZ), .MIN_ON_CYC(4), .MAX_ON_CYC(8), .MIN_OFF_CYC(2), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .heat_req     (heat_req),
    .cool_req     (cool_req),
    .zone_grant   (zone_grant),
    .heater_on    (heater_on),
    .cooler_on    (cooler_on),
    .req_conflict (req_conflict),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // {busy, heater_on, cooler_on, zone_grant}
  logic [6:0] outs;
  assign outs = {busy, heater_on, cooler_on, zone_grant};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pk(input bit b, input bit h, input bit c, input logic [3:0] g);
    return {b, h, c, g};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    heat_req = '0;
    cool_req = '0;
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'(0));
    reset = 1'b0;
  endtask

  logic [6:0] e;
  int         on_cnt;

  initial begin
    repeat (2) @(negedge clk);

    // 1: short heat request is stretched to the minimum on-time
    do_reset();
    heat_req = 4'b0100;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      e = (i <= 4) ? pk(1, 1, 0, 4'b0100) : (i <= 6) ? pk(1, 0, 0, 4'b0000) : 7'd0;
      chk($sformatf("t1_c%0d", i), 32'(outs), 32'(e));
      if (i == 2) heat_req = '0;
    end

    // 2: two contending zones alternate on the quantum
    do_reset();
    heat_req = 4'b0001;
    cool_req = 4'b0010;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if      (i <= 8)  e = pk(1, 1, 0, 4'b0001);
      else if (i <= 10) e = pk(1, 0, 0, 4'b0000);
      else if (i == 11) e = 7'd0;
      else if (i <= 19) e = pk(1, 0, 1, 4'b0010);
      else if (i <= 21) e = pk(1, 0, 0, 4'b0000);
      else if (i == 22) e = 7'd0;
      else              e = pk(1, 1, 0, 4'b0001);
      chk($sformatf("t2_c%0d", i), 32'(outs), 32'(e));
    end

    // 3: conflicting zone is ignored
    do_reset();
    heat_req = 4'b0100;
    cool_req = 4'b0100;
    #1 chk("t3_conflict", 32'(req_conflict), 32'(4'b0100));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_c%0d", i), 32'(outs), 32'(0));
    end

    // 4: asynchronous reset mid-run, then pointer restarts at zone 0
    do_reset();
    heat_req = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_c%0d", i), 32'(outs), 32'(pk(1, 1, 0, 4'b0100)));
    end
    #2 reset = 1'b1;
    #1 chk("t4_async_rst", 32'(outs), 32'(0));
    @(negedge clk);
    heat_req = 4'b0101;
    reset    = 1'b0;
    @(negedge clk);
    chk("t4_after_rst", 32'(outs), 32'(pk(1, 1, 0, 4'b0001)));

    // 5: sole requester is never preempted
    do_reset();
    cool_req = 4'b1000;
    on_cnt   = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (outs == pk(1, 0, 1, 4'b1000)) on_cnt++;
    end
    chk("t5_cool_cycles", 32'(on_cnt), 32'd45);

    // 6: mode flip while running counts as a drop
    do_reset();
    heat_req = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if      (i <= 5) e = pk(1, 1, 0, 4'b0010);
      else if (i <= 7) e = pk(1, 0, 0, 4'b0000);
      else if (i == 8) e = 7'd0;
      else             e = pk(1, 0, 1, 4'b0010);
      chk($sformatf("t6_c%0d", i), 32'(outs), 32'(e));
      if (i == 5) begin
        heat_req = '0;
        cool_req = 4'b0010;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
